ad_avg_tx: RTL and testbench
============================

AD_AVG_TX -- requirements
Module: ad_avg_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 12, ADC sample width, legal range 9..16.
REQ-002 SHALL have parameter AVG_LOG2, default 2, log2 of the moving-average window depth (1..5).
REQ-003 SHALL have parameter DECIM, default 1024, number of averages per transmitted average (>=1).
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port sample_in, input, DATA_W, ADC sample, qualified by sample_vld.
REQ-007 SHALL have port sample_vld, input, 1, one-cycle sample strobe.
REQ-008 SHALL have port avg_out, output, DATA_W, current window average.
REQ-009 SHALL have port avg_vld, output, 1, one-cycle strobe marking a new avg_out.
REQ-010 SHALL have port tx_data, output, 8, byte toward the UART byte transmitter.
REQ-011 SHALL have port tx_valid, output, 1, tx_data valid.
REQ-012 SHALL have port tx_ready, input, 1, transmitter accepts tx_data.
REQ-013 SHALL have port overrun, output, 1, one-cycle pulse when a decimated average is dropped.

Function
REQ-014 SHALL keep a window of N=2^AVG_LOG2 samples and a running sum of width DATA_W+AVG_LOG2; on sample_vld: sum <= sum + sample_in - oldest, with the window shifted.
REQ-015 SHALL drive avg_out = (sum_next >> AVG_LOG2), truncating, registered 1 cycle after sample_vld.
REQ-016 SHALL suppress avg_vld until N samples have been accepted since reset; after that, avg_vld SHALL pulse once per sample_vld.
REQ-017 SHALL count avg_vld pulses modulo DECIM; on the pulse where the count wraps from DECIM-1 to 0, the average SHALL be offered for transmission.
REQ-018 SHALL use TX FSM states IDLE, HDR, HI, LO; an offered average SHALL be captured only in IDLE, or in LO on the cycle in which the LO handshake completes.
REQ-019 SHALL drop an offered average not captured under REQ-018 and pulse overrun on that cycle.
REQ-020 SHALL send HI = avg[DATA_W-1:8] zero-extended to 8 bits, then LO = avg[7:0].
REQ-021 SHALL hold tx_valid and tx_data stable until tx_valid&&tx_ready, and advance the state only on that handshake.
REQ-022 SHALL assert tx_valid in the cycle after capture; LO handshake SHALL return to IDLE, or to the first byte state if a capture occurred in that cycle.
REQ-023 SHALL keep the averaging path independent of TX backpressure; samples are never stalled.

Reset
REQ-024 SHALL on rst clear window, sum, fill count, decimation count and FSM (IDLE); avg_out=0, avg_vld=0, tx_data=0, tx_valid=0, overrun=0.
REQ-025 SHALL abort any frame in progress on rst; no partial-frame completion after release.

Configuration
REQ-026 SHALL with AD_AVG_HDR_EN defined send header byte 0xA5 (state HDR) before HI for every frame.
REQ-027 SHALL without AD_AVG_HDR_EN go IDLE->HI directly; HDR is unreachable.

Structure
REQ-028 SHALL place the FSM state enum, header constant 0xA5 and the sum-width function in package ad_avg_pkg.
REQ-029 SHALL implement the window and running sum in sub-module ad_avg_win (ports: clk, rst, sample_in, sample_vld, avg_out, avg_vld).

Verification
REQ-030 DATA_W=12, AVG_LOG2=2: samples 100,200,300,400 -> no avg_vld on the first 3, avg_out=250 with avg_vld 1 cycle after the 4th.
REQ-031 Constant 0xFFF for 8 samples -> avg_out=0xFFF, no sum overflow.
REQ-032 DECIM=4, tx_ready=1, average 0xABC, HDR_EN on -> bytes 0xA5,0x0A,0xBC; HDR_EN off -> bytes 0x0A,0xBC.
REQ-033 tx_ready held 0 and a second offer while in HI -> overrun pulses once and tx_data stays 0x0A until ready.
REQ-034 Offer coinciding with the LO handshake -> no overrun, and the next frame starts the following cycle.
REQ-035 rst asserted mid-HI -> tx_valid is 0 immediately, and the first post-reset avg_vld appears only after 4 new samples.

Source files
------------

// File: rtl/ad_avg_pkg.sv
// Shared types and constants for the ad_avg_tx averaging front end.
// The TX state encoding is also what dbg_state_o presents to observers.
package ad_avg_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_HI   = 2'd2,
      S_LO   = 2'd3
   } tx_state_e;

   localparam logic [7:0] HDR_BYTE = 8'hA5;

   // Running sum must hold N full-scale samples without wrapping.
   function automatic int sum_width(input int data_w, input int avg_log2);
      return data_w + avg_log2;
   endfunction

endpackage

// File: rtl/ad_avg_win.sv
// Moving-average window: N = 2^AVG_LOG2 samples, running sum, truncating divide.
// avg_vld is held off until the window has been filled once since reset.
module ad_avg_win
   import ad_avg_pkg::*;
#(
   parameter int DATA_W   = 12,
   parameter int AVG_LOG2 = 2
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_vld,
   output logic [DATA_W-1:0] avg_out,
   output logic              avg_vld
);

   localparam int N     = 1 << AVG_LOG2;
   localparam int SUM_W = sum_width(DATA_W, AVG_LOG2);
   localparam logic [AVG_LOG2:0] FILL_N   = (AVG_LOG2+1)'(N);
   localparam logic [AVG_LOG2:0] FILL_ONE = (AVG_LOG2+1)'(1);

   logic [DATA_W-1:0] win_q [N];
   logic [SUM_W-1:0]  sum_q;
   logic [SUM_W-1:0]  sum_d;
   logic [AVG_LOG2:0] fill_q;
   logic [DATA_W-1:0] avg_q;
   logic              avg_vld_q;

   // Intermediate may wrap, but the final sum always fits in SUM_W.
   assign sum_d = sum_q + SUM_W'(sample_in) - SUM_W'(win_q[N-1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) win_q[i] <= '0;
         sum_q     <= '0;
         fill_q    <= '0;
         avg_q     <= '0;
         avg_vld_q <= 1'b0;
      end else begin
         avg_vld_q <= 1'b0;
         if (sample_vld) begin
            win_q[0] <= sample_in;
            for (int i = 1; i < N; i++) win_q[i] <= win_q[i-1];
            sum_q     <= sum_d;
            avg_q     <= sum_d[SUM_W-1:AVG_LOG2];
            avg_vld_q <= (fill_q >= (FILL_N - FILL_ONE));
            if (fill_q != FILL_N) fill_q <= fill_q + FILL_ONE;
         end
      end
   end

   assign avg_out = avg_q;
   assign avg_vld = avg_vld_q;

endmodule

// File: rtl/ad_avg_tx.sv
// Moving average of ADC samples, decimated and framed as bytes for a UART.
// Define AD_AVG_HDR_EN to prefix every frame with the 0xA5 header byte.
// tx handshake: tx_valid/tx_data hold until tx_valid && tx_ready; a byte moves only on that cycle.
module ad_avg_tx
   import ad_avg_pkg::*;
#(
   parameter int DATA_W   = 12,
   parameter int AVG_LOG2 = 2,
   parameter int DECIM    = 1024
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_vld,
   output logic [DATA_W-1:0] avg_out,
   output logic              avg_vld,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              overrun,
   output logic [1:0]        dbg_state_o
);

   localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   function automatic logic [7:0] hi_byte(input logic [DATA_W-1:0] v);
      return 8'(v >> 8);
   endfunction

   tx_state_e         state_q;
   logic [CNT_W-1:0]  dec_q;
   logic [DATA_W-1:0] cap_q;
   logic [7:0]        tx_data_q;
   logic              tx_valid_q;
   logic              offer;
   logic              hs;
   logic              can_cap;
   logic [7:0]        first_byte;
   tx_state_e         first_state;

   ad_avg_win #(
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2)
   ) u_win (
      .clk        (clk),
      .rst        (rst),
      .sample_in  (sample_in),
      .sample_vld (sample_vld),
      .avg_out    (avg_out),
      .avg_vld    (avg_vld)
   );

`ifdef AD_AVG_HDR_EN
   assign first_byte  = HDR_BYTE;
   assign first_state = S_HDR;
`else
   assign first_byte  = hi_byte(avg_out);
   assign first_state = S_HI;
`endif

   assign offer   = avg_vld && (dec_q == CNT_LAST);
   assign hs      = tx_valid_q && tx_ready;
   // A frame in flight can only be replaced as its LO byte leaves.
   assign can_cap = (state_q == S_IDLE) || ((state_q == S_LO) && hs);
   assign overrun = offer && !can_cap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_q <= '0;
      end else if (avg_vld) begin
         dec_q <= (dec_q == CNT_LAST) ? '0 : dec_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cap_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
      end else if (offer && can_cap) begin
         cap_q      <= avg_out;
         state_q    <= first_state;
         tx_data_q  <= first_byte;
         tx_valid_q <= 1'b1;
      end else if (hs) begin
         case (state_q)
`ifdef AD_AVG_HDR_EN
            S_HDR: begin
               state_q   <= S_HI;
               tx_data_q <= hi_byte(cap_q);
            end
`endif
            S_HI: begin
               state_q   <= S_LO;
               tx_data_q <= cap_q[7:0];
            end
            default: begin
               state_q    <= S_IDLE;
               tx_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ad_avg_tx.sv
// Self-checking bench for ad_avg_tx (DATA_W=12, AVG_LOG2=2, DECIM=4).
// Expected averages and byte stream come from a window-sum model over the samples sent.
module tb_ad_avg_tx;
   import ad_avg_pkg::*;

   localparam int DATA_W   = 12;
   localparam int AVG_LOG2 = 2;
   localparam int DECIM    = 4;
   localparam int N        = 4;
`ifdef AD_AVG_HDR_EN
   localparam bit HDR_ON = 1'b1;
`else
   localparam bit HDR_ON = 1'b0;
`endif
   localparam int FRAME_B = HDR_ON ? 3 : 2;
   localparam int LO_CYC  = HDR_ON ? 11 : 10;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DATA_W-1:0] sample_in = '0;
   logic              sample_vld = 1'b0;
   logic [DATA_W-1:0] avg_out;
   logic              avg_vld;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready = 1'b0;
   logic              overrun;
   logic [1:0]        dbg_state_o;

   int checks = 0;
   int failures = 0;
   int ovr_cnt = 0;
   int cyc_cnt = 0;

   logic [DATA_W-1:0] samp_q[$];
   logic [DATA_W-1:0] avg_got_q[$];
   logic [DATA_W-1:0] exp_avg_q[$];
   logic [7:0]        tx_got_q[$];
   logic [7:0]        exp_q[$];

   always #5 clk = ~clk;

   ad_avg_tx #(
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2),
      .DECIM    (DECIM)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sample_in   (sample_in),
      .sample_vld  (sample_vld),
      .avg_out     (avg_out),
      .avg_vld     (avg_vld),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .overrun     (overrun),
      .dbg_state_o (dbg_state_o)
   );

   // Passive monitor: records what the DUT emits, mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (avg_vld) avg_got_q.push_back(avg_out);
         if (tx_valid && tx_ready) tx_got_q.push_back(tx_data);
         if (overrun) ovr_cnt++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sample_vld = 1'b0;
      sample_in = '0;
      tx_ready = 1'b0;
      tick();
      tick();
      avg_got_q.delete();
      tx_got_q.delete();
      samp_q.delete();
      ovr_cnt = 0;
      rst = 1'b0;
   endtask

   task automatic send(input logic [DATA_W-1:0] v);
      sample_in = v;
      sample_vld = 1'b1;
      samp_q.push_back(v);
      tick();
      sample_vld = 1'b0;
   endtask

   task automatic push_frame(input logic [DATA_W-1:0] a);
      if (HDR_ON) exp_q.push_back(8'hA5);
      exp_q.push_back(8'(a >> 8));
      exp_q.push_back(a[7:0]);
   endtask

   // Every window of N consecutive samples yields one average; every DECIM-th is framed.
   task automatic build_expected();
      int s;
      int p;
      exp_avg_q.delete();
      exp_q.delete();
      p = 0;
      for (int k = N - 1; k < samp_q.size(); k++) begin
         s = 0;
         for (int j = 0; j < N; j++) s += int'(samp_q[k-j]);
         exp_avg_q.push_back(DATA_W'(s / N));
         p++;
         if (p % DECIM == 0) push_frame(DATA_W'(s / N));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sample_vld = 1'b1;
      sample_in = DATA_W'($urandom_range(0, 4095));
      tx_ready = 1'b1;
      tick();
      tick();
      @(negedge clk);
      checks++; if (avg_out !== '0) begin failures++; $display("FAIL reset_avg_out got=%0h exp=0", avg_out); end
      checks++; if (avg_vld !== 1'b0) begin failures++; $display("FAIL reset_avg_vld got=%b exp=0", avg_vld); end
      checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%0h exp=0", tx_data); end
      checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
      checks++; if (dbg_state_o !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state_o, S_IDLE); end
      sample_vld = 1'b0;
   endtask

   task automatic test_first_window();
      logic [DATA_W-1:0] vals[4];
      vals = '{12'd100, 12'd200, 12'd300, 12'd400};
      do_reset();
      for (int k = 0; k < 3; k++) begin
         send(vals[k]);
         checks++; if (avg_vld !== 1'b0) begin failures++; $display("FAIL fill_no_vld sample=%0d got=%b exp=0", k + 1, avg_vld); end
      end
      send(vals[3]);
      checks++; if (avg_vld !== 1'b1) begin failures++; $display("FAIL fill_vld got=%b exp=1", avg_vld); end
      checks++; if (avg_out !== 12'd250) begin failures++; $display("FAIL fill_avg got=%0d exp=250", avg_out); end
      tick();
      checks++; if (avg_vld !== 1'b0) begin failures++; $display("FAIL vld_one_cycle got=%b exp=0", avg_vld); end
   endtask

   task automatic test_full_scale();
      do_reset();
      tx_ready = 1'b1;
      for (int k = 0; k < 8; k++) send(12'hFFF);
      checks++; if (avg_out !== 12'hFFF) begin failures++; $display("FAIL full_scale_avg got=%0h exp=fff", avg_out); end
      repeat (8) tick();
      build_expected();
      checks++; if (avg_got_q.size() !== exp_avg_q.size()) begin failures++; $display("FAIL full_scale_count got=%0d exp=%0d", avg_got_q.size(), exp_avg_q.size()); end
      for (int i = 0; i < avg_got_q.size() && i < exp_avg_q.size(); i++) begin
         checks++; if (avg_got_q[i] !== exp_avg_q[i]) begin failures++; $display("FAIL full_scale_avg[%0d] got=%0h exp=%0h", i, avg_got_q[i], exp_avg_q[i]); end
      end
   endtask

   task automatic test_frame();
      exp_q.delete();
      push_frame(12'hABC);
      do_reset();
      tx_ready = 1'b1;
      for (int k = 0; k < 7; k++) send(12'hABC);
      repeat (8) tick();
      checks++; if (tx_got_q.size() !== exp_q.size()) begin failures++; $display("FAIL frame_len got=%0d exp=%0d", tx_got_q.size(), exp_q.size()); end
      for (int i = 0; i < tx_got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (tx_got_q[i] !== exp_q[i]) begin failures++; $display("FAIL frame_byte[%0d] got=%0h exp=%0h", i, tx_got_q[i], exp_q[i]); end
      end
      checks++; if (ovr_cnt !== 0) begin failures++; $display("FAIL frame_overrun got=%0d exp=0", ovr_cnt); end
   endtask

   task automatic test_overrun();
      exp_q.delete();
      push_frame(12'hABC);
      do_reset();
      for (int cyc = 1; cyc <= 24; cyc++) begin
         sample_vld = (cyc <= 12);
         sample_in = 12'hABC;
         tx_ready = (HDR_ON && cyc == 9) || (cyc >= 20);
         @(negedge clk);
         if (cyc == 12) begin
            checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_pulse got=%b exp=1", overrun); end
         end
         if (cyc >= 10 && cyc <= 19) begin
            checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h0A) begin failures++; $display("FAIL overrun_hold cyc=%0d got=%b/%0h exp=1/0a", cyc, tx_valid, tx_data); end
         end
         tick();
      end
      checks++; if (ovr_cnt !== 1) begin failures++; $display("FAIL overrun_count got=%0d exp=1", ovr_cnt); end
      checks++; if (avg_got_q.size() !== 9) begin failures++; $display("FAIL overrun_avg_count got=%0d exp=9", avg_got_q.size()); end
      checks++; if (tx_got_q.size() !== exp_q.size()) begin failures++; $display("FAIL overrun_len got=%0d exp=%0d", tx_got_q.size(), exp_q.size()); end
      for (int i = 0; i < tx_got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (tx_got_q[i] !== exp_q[i]) begin failures++; $display("FAIL overrun_byte[%0d] got=%0h exp=%0h", i, tx_got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int k = 0; k < 12; k++) samp_q.push_back(DATA_W'($urandom_range(0, 4095)));
      build_expected();
      for (int cyc = 1; cyc <= 24; cyc++) begin
         sample_vld = (cyc <= 12);
         if (cyc <= 12) sample_in = samp_q[cyc-1];
         tx_ready = !(cyc >= LO_CYC && cyc <= 11);
         @(negedge clk);
         if (cyc == 12) begin
            checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_no_overrun got=%b exp=0", overrun); end
            checks++; if (dbg_state_o !== S_LO) begin failures++; $display("FAIL b2b_in_lo got=%0d exp=%0d", dbg_state_o, S_LO); end
         end
         if (cyc == 13) begin
            checks++; if (tx_valid !== 1'b1 || tx_data !== exp_q[FRAME_B]) begin failures++; $display("FAIL b2b_next_frame got=%b/%0h exp=1/%0h", tx_valid, tx_data, exp_q[FRAME_B]); end
         end
         tick();
      end
      checks++; if (ovr_cnt !== 0) begin failures++; $display("FAIL b2b_overrun_count got=%0d exp=0", ovr_cnt); end
      checks++; if (tx_got_q.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_len got=%0d exp=%0d", tx_got_q.size(), exp_q.size()); end
      for (int i = 0; i < tx_got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (tx_got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_byte[%0d] got=%0h exp=%0h", i, tx_got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid_frame();
      int s;
      do_reset();
      for (int cyc = 1; cyc <= 10; cyc++) begin
         sample_vld = (cyc <= 8);
         sample_in = DATA_W'($urandom_range(0, 4095));
         tx_ready = HDR_ON && (cyc == 9);
         @(negedge clk);
         if (cyc == 10) begin
            checks++; if (dbg_state_o !== S_HI) begin failures++; $display("FAIL rst_pre_state got=%0d exp=%0d", dbg_state_o, S_HI); end
            rst = 1'b1;
            #1;
            checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
            checks++; if (dbg_state_o !== S_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state_o, S_IDLE); end
         end else begin
            tick();
         end
      end
      sample_vld = 1'b0;
      tx_ready = 1'b1;
      tick();
      tick();
      avg_got_q.delete();
      tx_got_q.delete();
      samp_q.delete();
      ovr_cnt = 0;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         send(DATA_W'($urandom_range(0, 4095)));
         checks++; if (avg_vld !== 1'b0) begin failures++; $display("FAIL rst_refill_no_vld sample=%0d got=%b exp=0", k + 1, avg_vld); end
      end
      send(DATA_W'($urandom_range(0, 4095)));
      s = 0;
      foreach (samp_q[i]) s += int'(samp_q[i]);
      checks++; if (avg_vld !== 1'b1 || avg_out !== DATA_W'(s / N)) begin failures++; $display("FAIL rst_refill_avg got=%b/%0d exp=1/%0d", avg_vld, avg_out, s / N); end
      repeat (10) tick();
      checks++; if (tx_got_q.size() !== 0) begin failures++; $display("FAIL rst_no_partial got=%0d exp=0", tx_got_q.size()); end
   endtask

   task automatic rand_cycle(input logic vld, input logic [DATA_W-1:0] val);
      sample_vld = vld;
      sample_in = val;
      // Ready is random but never low for more than 3 cycles in a row.
      tx_ready = ($urandom_range(0, 1) == 1) || (cyc_cnt % 4 == 0);
      if (vld) samp_q.push_back(val);
      tick();
      cyc_cnt++;
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] v;
      do_reset();
      cyc_cnt = 0;
      for (int k = 0; k < 48; k++) begin
         case ($urandom_range(0, 5))
            0: v = '0;
            1: v = 12'hFFF;
            default: v = DATA_W'($urandom_range(0, 4095));
         endcase
         rand_cycle(1'b1, v);
         repeat ($urandom_range(3, 5)) rand_cycle(1'b0, '0);
      end
      sample_vld = 1'b0;
      tx_ready = 1'b1;
      repeat (20) tick();
      build_expected();
      checks++; if (avg_got_q.size() !== exp_avg_q.size()) begin failures++; $display("FAIL rand_avg_count got=%0d exp=%0d", avg_got_q.size(), exp_avg_q.size()); end
      for (int i = 0; i < avg_got_q.size() && i < exp_avg_q.size(); i++) begin
         checks++; if (avg_got_q[i] !== exp_avg_q[i]) begin failures++; $display("FAIL rand_avg[%0d] got=%0d exp=%0d", i, avg_got_q[i], exp_avg_q[i]); end
      end
      checks++; if (tx_got_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand_tx_len got=%0d exp=%0d", tx_got_q.size(), exp_q.size()); end
      for (int i = 0; i < tx_got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (tx_got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_tx_byte[%0d] got=%0h exp=%0h", i, tx_got_q[i], exp_q[i]); end
      end
      checks++; if (ovr_cnt !== 0) begin failures++; $display("FAIL rand_overrun got=%0d exp=0", ovr_cnt); end
   endtask

   initial begin
      test_reset();
      test_first_window();
      test_full_scale();
      test_frame();
      test_overrun();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
